axi_llc_way_xbar: RTL and testbench
===================================

# axi_llc_way_xbar

Crossbar between the LLC cache units (evict, refill, write-channel and read-channel units) and the `SetAssociativity` data-way instances. It arbitrates unit requests onto the shared way request bus and steers each request to the way selected by its one-hot `way_ind`. It routes way read responses back to the requesting unit by their `cache_unit` tag. It is the stage directly upstream and downstream of every data way; both paths are combinational, with round-robin state and grant locks in registers.

## Interface
- `Cfg`, `'0`: static `axi_llc_pkg::llc_cfg_t`; `Cfg.SetAssociativity` gives the number of ways.
- `NumUnits`, `4`: number of cache units. Unit index equals the `axi_llc_pkg::cache_unit_e` value.
- `way_inp_t`, `logic`: way request struct with fields `cache_unit`, `way_ind`, `line_addr`, `blk_offset`, `we`, `data`, `strb`.
- `way_oup_t`, `logic`: way response struct with fields `cache_unit` and `data`.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, **synchronous, active-low**. Single clock domain.
- `unit_inp_i` in `[NumUnits]` `way_inp_t`: unit requests.
- `unit_inp_valid_i` / `unit_inp_ready_o`, in / out, `NumUnits`: request handshake per unit.
- `way_inp_o` out `way_inp_t`: request broadcast to all ways.
- `way_inp_valid_o` / `way_inp_ready_i`, out / in, `SetAssociativity`: per-way request handshake.
- `way_out_i` in `[SetAssociativity]` `way_oup_t`: way read responses.
- `way_out_valid_i` / `way_out_ready_o`, in / out, `SetAssociativity`: per-way response handshake.
- `unit_out_o` in/out `[NumUnits]` `way_oup_t` (direction out): responses delivered to units.
- `unit_out_valid_o` / `unit_out_ready_i`, out / in, `NumUnits`: response handshake per unit.

## Operation
**Request path (one request per cycle in total):**
- A round-robin arbiter over `unit_inp_valid_i` selects unit g. `way_inp_o` = `unit_inp_i[g]`.
- `way_inp_valid_o[w]` = `valid[g]` & `way_ind[w]`.
- `unit_inp_ready_o[g]` = AND of `way_inp_ready_i` over the set bits of `way_ind`. All other units see ready 0.
- `way_ind` is required to be one-hot; a simulation assertion checks this.
  - If `way_ind` is zero: the request is accepted (ready 1) and dropped.
  - If `way_ind` is multi-hot: the request is broadcast to every selected way.
- Lock: if a grant is given without a handshake, the grant is registered and held until the handshake. Priority does not change while locked.
- After each handshake, the priority pointer moves to g+1 (mod `NumUnits`).

**Response path, per unit u:**
- Candidate ways are those with `way_out_valid_i[w]` & (`way_out_i[w].cache_unit` == u).
- A round-robin arbiter per unit picks way k. `unit_out_o[u]` = `way_out_i[k]`, and `unit_out_valid_o[u]` is asserted.
- `way_out_ready_o[k]` = `unit_out_ready_i[u]`.
- Lock and pointer-advance rules are the same as on the request path.
- A response whose `cache_unit` is ≥ `NumUnits`: `way_out_ready_o` = 1 (drained), and an assertion fires.
- A way with no valid response sees `way_out_ready_o` = 0.

## Timing
- Zero-cycle latency on both paths: valid, data and ready are combinational from inputs plus registered arbiter state.
- No combinational path from any ready input to any valid output.
- Reset: all priority pointers are 0 and all locks are cleared. While input valids are low, every valid output is 0 and every ready output is 0.
- A reset asserted mid-lock drops the lock. Upstream and downstream handshake state is owned by the neighbours.
- Request and response transfers on the same cycle are independent.
- If several units all retarget one way, that way alone limits throughput; requests are never reordered per unit.
- Pointer wrap: `NumUnits`-1 → 0 and `SetAssociativity`-1 → 0.

## Structure
- `cache_unit_e` and `llc_cfg_t` come from `axi_llc_pkg`; this block adds no new package types.
- One sub-module, `axi_llc_rr_arb` (parameterised N, with lock and pointer), instantiated once for requests and `NumUnits` times for responses.

## Test plan
- **Single request:** unit 2 sends `way_ind`=4'b0100 while way 2 is ready → `way_inp_valid_o`=4'b0100 and `unit_inp_ready_o`=4'b0100 in the same cycle.
- **Round robin:** units 0, 1 and 3 all valid, all ways ready → grants in order 0, 1, 3, 0 over 4 cycles.
- **Lock:** unit 1 targets way 0 with `way_inp_ready_i[0]`=0 for 3 cycles, while unit 0 is also valid → grant stays on 1, then moves to 0 after the handshake.
- **Response contention:** ways 0 and 3 both return responses for `RChanUnit` → delivered on consecutive cycles, way 0 first. The stalled way's `way_out_ready_o` stays 0 and its data stays stable.
- **Independent units:** way 1 returns to `EvictUnit` and way 2 returns to `WChanUnit` in the same cycle → both are delivered in that cycle.
- **Reset and illegal `way_ind`:** reset applied mid-lock → all outputs 0 on the next edge. A request with `way_ind`=0 → accepted and dropped, and the assertion fires.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// LLC-wide shared types: cache unit identifiers and the static cache configuration.
package axi_llc_pkg;

  // Unit index used to tag way traffic. The tag is wider than the unit count so that
  // corrupted tags can be detected downstream.
  typedef enum logic [2:0] {
    EvictUnit  = 3'd0,
    RefillUnit = 3'd1,
    WChanUnit  = 3'd2,
    RChanUnit  = 3'd3
  } cache_unit_e;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
  } llc_cfg_t;

endpackage

// File: rtl/axi_llc_way_xbar_pkg.sv
// Way-bus payload layout shared by the way crossbar, its interface and the data ways.
package axi_llc_way_xbar_pkg;

  localparam int unsigned WayIndWidth    = 4;
  localparam int unsigned LineAddrWidth  = 10;
  localparam int unsigned BlkOffsetWidth = 3;
  localparam int unsigned DataWidth      = 64;
  localparam int unsigned StrbWidth      = DataWidth / 8;

  typedef struct packed {
    axi_llc_pkg::cache_unit_e    cache_unit;
    logic [WayIndWidth-1:0]      way_ind;
    logic [LineAddrWidth-1:0]    line_addr;
    logic [BlkOffsetWidth-1:0]   blk_offset;
    logic                        we;
    logic [DataWidth-1:0]        data;
    logic [StrbWidth-1:0]        strb;
  } way_inp_t;

  typedef struct packed {
    axi_llc_pkg::cache_unit_e    cache_unit;
    logic [DataWidth-1:0]        data;
  } way_oup_t;

  // A request may complete only once every way it selects is ready; an empty
  // selection is trivially ready so it gets drained.
  function automatic logic all_sel_ready(logic [WayIndWidth-1:0] way_ind,
                                         logic [WayIndWidth-1:0] ready);
    return &(ready | ~way_ind);
  endfunction

endpackage

// File: rtl/axi_llc_way_xbar_if.sv
// Bundle of all unit-side and way-side handshake channels around the way crossbar.
interface axi_llc_way_xbar_if #(
  parameter int unsigned NumUnits = 4,
  parameter int unsigned NumWays  = axi_llc_way_xbar_pkg::WayIndWidth
) ();
  import axi_llc_way_xbar_pkg::*;

  way_inp_t            unit_inp [NumUnits];
  logic [NumUnits-1:0] unit_inp_valid;
  logic [NumUnits-1:0] unit_inp_ready;

  way_inp_t            way_inp;
  logic [NumWays-1:0]  way_inp_valid;
  logic [NumWays-1:0]  way_inp_ready;

  way_oup_t            way_out [NumWays];
  logic [NumWays-1:0]  way_out_valid;
  logic [NumWays-1:0]  way_out_ready;

  way_oup_t            unit_out [NumUnits];
  logic [NumUnits-1:0] unit_out_valid;
  logic [NumUnits-1:0] unit_out_ready;

  // Crossbar view.
  modport slave (
    input  unit_inp, unit_inp_valid, way_inp_ready, way_out, way_out_valid, unit_out_ready,
    output unit_inp_ready, way_inp, way_inp_valid, way_out_ready, unit_out, unit_out_valid
  );

  // Neighbour (units and ways) view.
  modport master (
    output unit_inp, unit_inp_valid, way_inp_ready, way_out, way_out_valid, unit_out_ready,
    input  unit_inp_ready, way_inp, way_inp_valid, way_out_ready, unit_out, unit_out_valid
  );

endinterface

// File: rtl/axi_llc_way_xbar_rr_arb.sv
// Round-robin arbiter with grant lock: a grant without handshake is held until it completes.
module axi_llc_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            ack_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] cand;
  logic            found;

  // Select the first requester at or after the pointer unless a grant is locked.
  always_comb begin
    sel   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (lock_q) begin
      sel = lock_idx_q;
    end
    idx_o      = sel;
    valid_o    = req_i[sel];
    gnt_o      = '0;
    gnt_o[sel] = valid_o;
  end

  // Advance past the winner on handshake; otherwise pin the outstanding grant.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (valid_o && ack_i) begin
      lock_d = 1'b0;
      ptr_d  = (sel == IdxW'(N - 1)) ? '0 : sel + 1'b1;
    end else if (valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/axi_llc_way_xbar.sv
// Crossbar between LLC cache units and data ways: arbitrated request broadcast, tagged
// response return. Both directions are combinational around registered arbiter state.
module axi_llc_way_xbar
  import axi_llc_pkg::*;
  import axi_llc_way_xbar_pkg::*;
#(
  parameter llc_cfg_t    Cfg      = '{SetAssociativity: WayIndWidth, NumLines: 32'd256,
                                      NumBlocks: 32'd8},
  parameter int unsigned NumUnits = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  axi_llc_way_xbar_if.slave bus
);

  localparam int unsigned NumWays  = Cfg.SetAssociativity;
  localparam int unsigned UnitIdxW = (NumUnits > 1) ? $clog2(NumUnits) : 1;
  localparam int unsigned WayIdxW  = (NumWays > 1) ? $clog2(NumWays) : 1;

  // Request path.
  logic [NumUnits-1:0] req_gnt;
  logic [UnitIdxW-1:0] req_idx;
  logic                req_valid;
  logic                req_ack;
  way_inp_t            req_sel;

  axi_llc_rr_arb #(
    .N(NumUnits)
  ) i_req_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (bus.unit_inp_valid),
    .ack_i  (req_ack),
    .gnt_o  (req_gnt),
    .idx_o  (req_idx),
    .valid_o(req_valid)
  );

  // Broadcast the granted request and steer valid by its way select.
  always_comb begin
    req_sel            = bus.unit_inp[req_idx];
    req_ack            = req_valid & all_sel_ready(req_sel.way_ind, bus.way_inp_ready);
    bus.way_inp        = req_sel;
    bus.way_inp_valid  = req_valid ? req_sel.way_ind : '0;
    bus.unit_inp_ready = req_ack ? req_gnt : '0;
  end

  // Response path.
  logic [NumUnits-1:0][NumWays-1:0] rsp_req;
  logic [NumUnits-1:0][NumWays-1:0] rsp_gnt;
  logic [NumUnits-1:0][WayIdxW-1:0] rsp_idx;
  logic [NumUnits-1:0]              rsp_valid;
  logic [NumUnits-1:0]              rsp_ack;
  logic [NumWays-1:0]               rsp_illegal;

  // Sort valid way responses by destination unit; out-of-range tags are flagged for draining.
  always_comb begin
    rsp_req     = '0;
    rsp_illegal = '0;
    for (int unsigned w = 0; w < NumWays; w++) begin
      if (32'(bus.way_out[w].cache_unit) >= NumUnits) begin
        rsp_illegal[w] = bus.way_out_valid[w];
      end
      for (int unsigned u = 0; u < NumUnits; u++) begin
        if (32'(bus.way_out[w].cache_unit) == u) begin
          rsp_req[u][w] = bus.way_out_valid[w];
        end
      end
    end
  end

  for (genvar u = 0; u < NumUnits; u++) begin : g_rsp
    axi_llc_rr_arb #(
      .N(NumWays)
    ) i_rsp_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (rsp_req[u]),
      .ack_i  (rsp_ack[u]),
      .gnt_o  (rsp_gnt[u]),
      .idx_o  (rsp_idx[u]),
      .valid_o(rsp_valid[u])
    );
  end

  assign rsp_ack = rsp_valid & bus.unit_out_ready;

  // Deliver each unit's winning response and return its ready to the owning way.
  always_comb begin
    bus.way_out_ready  = rsp_illegal;
    bus.unit_out_valid = rsp_valid;
    for (int unsigned u = 0; u < NumUnits; u++) begin
      bus.unit_out[u]   = bus.way_out[rsp_idx[u]];
      bus.way_out_ready = bus.way_out_ready | (rsp_gnt[u] & {NumWays{bus.unit_out_ready[u]}});
    end
  end

  // Zero or multi-hot way selects are tolerated in hardware but flagged in simulation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) req_valid |-> $onehot(req_sel.way_ind))
    else $warning("axi_llc_way_xbar: way_ind not one-hot (%b)", req_sel.way_ind);

  for (genvar w = 0; w < NumWays; w++) begin : g_tag_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni) !rsp_illegal[w])
      else $warning("axi_llc_way_xbar: way %0d returned out-of-range cache_unit", w);
  end

endmodule

// File: tb/tb_axi_llc_way_xbar.sv
// Directed bench for the LLC way crossbar: arbitration, locking, response routing, reset.
module tb_axi_llc_way_xbar;
  import axi_llc_pkg::*;
  import axi_llc_way_xbar_pkg::*;

  localparam int unsigned NumUnits = 4;
  localparam int unsigned NumWays  = 4;
  localparam llc_cfg_t Cfg = '{SetAssociativity: NumWays, NumLines: 32'd256, NumBlocks: 32'd8};

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  axi_llc_way_xbar_if #(.NumUnits(NumUnits), .NumWays(NumWays)) bus ();

  axi_llc_way_xbar #(
    .Cfg     (Cfg),
    .NumUnits(NumUnits)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  function automatic way_inp_t mk_req(cache_unit_e cu, logic [3:0] wi, logic [63:0] d);
    way_inp_t r;
    r            = '0;
    r.cache_unit = cu;
    r.way_ind    = wi;
    r.line_addr  = d[9:0];
    r.data       = d;
    r.strb       = '1;
    return r;
  endfunction

  function automatic way_oup_t mk_rsp(cache_unit_e cu, logic [63:0] d);
    way_oup_t r;
    r.cache_unit = cu;
    r.data       = d;
    return r;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < NumUnits; i++) bus.unit_inp[i] = '0;
    for (int i = 0; i < NumWays; i++) bus.way_out[i] = '0;
    bus.unit_inp_valid = '0;
    bus.way_inp_ready  = '0;
    bus.way_out_valid  = '0;
    bus.unit_out_ready = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_ni = 1'b0;
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    next_cycle();
    n_tests++; if (bus.way_inp_valid !== 4'b0000) begin n_fail++;
      $display("FAIL reset_way_inp_valid: got %b exp 0000", bus.way_inp_valid); end
    n_tests++; if (bus.unit_inp_ready !== 4'b0000) begin n_fail++;
      $display("FAIL reset_unit_inp_ready: got %b exp 0000", bus.unit_inp_ready); end
    n_tests++; if (bus.unit_out_valid !== 4'b0000) begin n_fail++;
      $display("FAIL reset_unit_out_valid: got %b exp 0000", bus.unit_out_valid); end
    n_tests++; if (bus.way_out_ready !== 4'b0000) begin n_fail++;
      $display("FAIL reset_way_out_ready: got %b exp 0000", bus.way_out_ready); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    bus.unit_inp[2]    = mk_req(WChanUnit, 4'b0100, 64'hA5A5_0000_1234);
    bus.unit_inp_valid = 4'b0100;
    bus.way_inp_ready  = 4'b0100;
    #3;
    n_tests++; if (bus.way_inp_valid !== 4'b0100) begin n_fail++;
      $display("FAIL single_way_valid: got %b exp 0100", bus.way_inp_valid); end
    n_tests++; if (bus.unit_inp_ready !== 4'b0100) begin n_fail++;
      $display("FAIL single_unit_ready: got %b exp 0100", bus.unit_inp_ready); end
    n_tests++; if (bus.way_inp.data !== 64'hA5A5_0000_1234) begin n_fail++;
      $display("FAIL single_data: got %h exp a5a500001234", bus.way_inp.data); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [4];
    exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    apply_reset();
    bus.unit_inp[0]    = mk_req(EvictUnit, 4'b0001, 64'h10);
    bus.unit_inp[1]    = mk_req(RefillUnit, 4'b0010, 64'h11);
    bus.unit_inp[3]    = mk_req(RChanUnit, 4'b1000, 64'h13);
    bus.unit_inp_valid = 4'b1011;
    bus.way_inp_ready  = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #3;
      n_tests++; if (bus.unit_inp_ready !== exp_gnt[c]) begin n_fail++;
        $display("FAIL rr_ready[%0d]: got %b exp %b", c, bus.unit_inp_ready, exp_gnt[c]); end
      n_tests++; if (bus.way_inp_valid !== exp_gnt[c]) begin n_fail++;
        $display("FAIL rr_valid[%0d]: got %b exp %b", c, bus.way_inp_valid, exp_gnt[c]); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    apply_reset();
    bus.unit_inp[0]    = mk_req(EvictUnit, 4'b0010, 64'h20);
    bus.unit_inp[1]    = mk_req(RefillUnit, 4'b0001, 64'h21);
    bus.way_inp_ready  = 4'b1110;
    bus.unit_inp_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_tests++; if (bus.way_inp_valid !== 4'b0001) begin n_fail++;
        $display("FAIL lock_hold_valid[%0d]: got %b exp 0001", c, bus.way_inp_valid); end
      n_tests++; if (bus.unit_inp_ready !== 4'b0000) begin n_fail++;
        $display("FAIL lock_hold_ready[%0d]: got %b exp 0000", c, bus.unit_inp_ready); end
      next_cycle();
      bus.unit_inp_valid = 4'b0011;
    end
    bus.way_inp_ready = 4'b1111;
    #3;
    n_tests++; if (bus.unit_inp_ready !== 4'b0010) begin n_fail++;
      $display("FAIL lock_release: got %b exp 0010", bus.unit_inp_ready); end
    next_cycle();
    #3;
    n_tests++; if (bus.unit_inp_ready !== 4'b0001) begin n_fail++;
      $display("FAIL lock_next_ready: got %b exp 0001", bus.unit_inp_ready); end
    n_tests++; if (bus.way_inp_valid !== 4'b0010) begin n_fail++;
      $display("FAIL lock_next_valid: got %b exp 0010", bus.way_inp_valid); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_resp_contention();
    apply_reset();
    bus.way_out[0]     = mk_rsp(RChanUnit, 64'hA0);
    bus.way_out[3]     = mk_rsp(RChanUnit, 64'hA3);
    bus.way_out_valid  = 4'b1001;
    bus.unit_out_ready = 4'b0000;
    #3;
    n_tests++; if (bus.unit_out_valid !== 4'b1000) begin n_fail++;
      $display("FAIL rsp_stall_valid: got %b exp 1000", bus.unit_out_valid); end
    n_tests++; if (bus.way_out_ready !== 4'b0000) begin n_fail++;
      $display("FAIL rsp_stall_ready: got %b exp 0000", bus.way_out_ready); end
    next_cycle();
    bus.unit_out_ready = 4'b1111;
    #3;
    n_tests++; if (bus.unit_out[3].data !== 64'hA0) begin n_fail++;
      $display("FAIL rsp_first_data: got %h exp a0", bus.unit_out[3].data); end
    n_tests++; if (bus.way_out_ready !== 4'b0001) begin n_fail++;
      $display("FAIL rsp_first_ready: got %b exp 0001", bus.way_out_ready); end
    next_cycle();
    bus.way_out_valid = 4'b1000;
    #3;
    n_tests++; if (bus.unit_out_valid !== 4'b1000) begin n_fail++;
      $display("FAIL rsp_second_valid: got %b exp 1000", bus.unit_out_valid); end
    n_tests++; if (bus.unit_out[3].data !== 64'hA3) begin n_fail++;
      $display("FAIL rsp_second_data: got %h exp a3", bus.unit_out[3].data); end
    n_tests++; if (bus.way_out_ready !== 4'b1000) begin n_fail++;
      $display("FAIL rsp_second_ready: got %b exp 1000", bus.way_out_ready); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_independent();
    apply_reset();
    bus.way_out[1]     = mk_rsp(EvictUnit, 64'hB1);
    bus.way_out[2]     = mk_rsp(WChanUnit, 64'hB2);
    bus.way_out_valid  = 4'b0110;
    bus.unit_out_ready = 4'b1111;
    bus.unit_inp[3]    = mk_req(RChanUnit, 4'b1000, 64'h33);
    bus.unit_inp_valid = 4'b1000;
    bus.way_inp_ready  = 4'b1000;
    #3;
    n_tests++; if (bus.unit_out_valid !== 4'b0101) begin n_fail++;
      $display("FAIL indep_valid: got %b exp 0101", bus.unit_out_valid); end
    n_tests++; if (bus.unit_out[0].data !== 64'hB1) begin n_fail++;
      $display("FAIL indep_data0: got %h exp b1", bus.unit_out[0].data); end
    n_tests++; if (bus.unit_out[2].data !== 64'hB2) begin n_fail++;
      $display("FAIL indep_data2: got %h exp b2", bus.unit_out[2].data); end
    n_tests++; if (bus.way_out_ready !== 4'b0110) begin n_fail++;
      $display("FAIL indep_ready: got %b exp 0110", bus.way_out_ready); end
    n_tests++; if (bus.unit_inp_ready !== 4'b1000) begin n_fail++;
      $display("FAIL indep_req_ready: got %b exp 1000", bus.unit_inp_ready); end
    bus.unit_out_ready = 4'b1110;
    #1;
    n_tests++; if (bus.way_out_ready !== 4'b0100) begin n_fail++;
      $display("FAIL indep_stall_ready: got %b exp 0100", bus.way_out_ready); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    bus.unit_inp[0]    = mk_req(EvictUnit, 4'b0010, 64'h40);
    bus.unit_inp[1]    = mk_req(RefillUnit, 4'b0001, 64'h41);
    bus.unit_inp_valid = 4'b0010;
    bus.way_inp_ready  = 4'b0000;
    next_cycle();
    rst_ni             = 1'b0;
    bus.unit_inp_valid = 4'b0000;
    next_cycle();
    n_tests++; if (bus.way_inp_valid !== 4'b0000) begin n_fail++;
      $display("FAIL rstlock_way_valid: got %b exp 0000", bus.way_inp_valid); end
    n_tests++; if (bus.unit_inp_ready !== 4'b0000) begin n_fail++;
      $display("FAIL rstlock_unit_ready: got %b exp 0000", bus.unit_inp_ready); end
    rst_ni             = 1'b1;
    bus.unit_inp_valid = 4'b0011;
    bus.way_inp_ready  = 4'b1111;
    #3;
    n_tests++; if (bus.unit_inp_ready !== 4'b0001) begin n_fail++;
      $display("FAIL rstlock_cleared: got %b exp 0001", bus.unit_inp_ready); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_illegal();
    apply_reset();
    bus.unit_inp[2]    = mk_req(WChanUnit, 4'b0000, 64'h50);
    bus.unit_inp_valid = 4'b0100;
    #3;
    n_tests++; if (bus.unit_inp_ready !== 4'b0100) begin n_fail++;
      $display("FAIL zero_ind_ready: got %b exp 0100", bus.unit_inp_ready); end
    n_tests++; if (bus.way_inp_valid !== 4'b0000) begin n_fail++;
      $display("FAIL zero_ind_valid: got %b exp 0000", bus.way_inp_valid); end
    next_cycle();
    clear_inputs();
    bus.unit_inp[1]    = mk_req(RefillUnit, 4'b0110, 64'h51);
    bus.unit_inp_valid = 4'b0010;
    bus.way_inp_ready  = 4'b0100;
    #3;
    n_tests++; if (bus.way_inp_valid !== 4'b0110) begin n_fail++;
      $display("FAIL multi_valid: got %b exp 0110", bus.way_inp_valid); end
    n_tests++; if (bus.unit_inp_ready !== 4'b0000) begin n_fail++;
      $display("FAIL multi_partial_ready: got %b exp 0000", bus.unit_inp_ready); end
    bus.way_inp_ready = 4'b0110;
    #1;
    n_tests++; if (bus.unit_inp_ready !== 4'b0010) begin n_fail++;
      $display("FAIL multi_full_ready: got %b exp 0010", bus.unit_inp_ready); end
    next_cycle();
    clear_inputs();
    bus.way_out[1]     = mk_rsp(cache_unit_e'(3'd5), 64'h52);
    bus.way_out_valid  = 4'b0010;
    bus.unit_out_ready = 4'b1111;
    #3;
    n_tests++; if (bus.way_out_ready !== 4'b0010) begin n_fail++;
      $display("FAIL bad_tag_ready: got %b exp 0010", bus.way_out_ready); end
    n_tests++; if (bus.unit_out_valid !== 4'b0000) begin n_fail++;
      $display("FAIL bad_tag_valid: got %b exp 0000", bus.unit_out_valid); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_resp_contention();
    test_independent();
    test_reset_mid_lock();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
